pearson_hash_scheduler: RTL and testbench

//  Round-robin scheduler sharing one Pearson hash step datapath among NUM_REQ byte-stream requesters.

---
 rtl/pearson_pkg.sv | 30 +++
 rtl/pearson_step.sv | 13 +
 rtl/pearson_hash_scheduler.sv | 148 ++++++++++++++
 tb/tb_pearson_hash_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pearson_pkg.sv
// rtl/pearson_pkg.sv - shared types, digest width and default permutation for the Pearson hash scheduler
// Optional feature macro: PEARSON_WIDE_EN (two-lane 16-bit digest).
package pearson_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

`ifdef PEARSON_WIDE_EN
    localparam int HASH_W = 16;
`else
    localparam int HASH_W = 8;
`endif

    localparam int TBL_DEPTH = 256;

    // Odd multiplier mod 256 is a bijection, so the default table is a true permutation.
    function automatic logic [TBL_DEPTH-1:0][7:0] gen_default_table();
        logic [TBL_DEPTH-1:0][7:0] t;
        for (int i = 0; i < TBL_DEPTH; i++) begin
            t[i] = 8'((i * 167 + 13) & 255);
        end
        return t;
    endfunction

    localparam logic [TBL_DEPTH-1:0][7:0] DEFAULT_TABLE = gen_default_table();

endpackage

// File: rtl/pearson_step.sv
// rtl/pearson_step.sv - one combinational Pearson hash step, h_next = table[h ^ byte]
module pearson_step
    import pearson_pkg::*;
(
    input  logic [TBL_DEPTH-1:0][7:0] tbl,
    input  logic [7:0]                h_in,
    input  logic [7:0]                data_in,
    output logic [7:0]                h_next
);

    assign h_next = tbl[h_in ^ data_in];

endmodule

// File: rtl/pearson_hash_scheduler.sv
// rtl/pearson_hash_scheduler.sv - round-robin scheduler sharing one Pearson hash datapath among requesters
// Optional feature macro: PEARSON_WIDE_EN (second lane, 16-bit digest).
module pearson_hash_scheduler
    import pearson_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tbl_wr_en,
    input  logic [7:0]           tbl_wr_addr,
    input  logic [7:0]           tbl_wr_data,
    output logic                 tbl_wr_ready,
    output logic                 hash_valid,
    output logic [HASH_W-1:0]    hash_data,
    output logic [ID_W-1:0]      hash_id,
    input  logic                 hash_ready,
    output logic                 busy
);

    state_t                      state;
    logic [ID_W-1:0]             rr_ptr;
    logic [ID_W-1:0]             grant;
    logic [TBL_DEPTH-1:0][7:0]   tbl;
    logic [7:0]                  h0;
    logic [7:0]                  h0_next;
    logic [7:0]                  sel_byte;
    logic                        sel_last;
    logic                        accept;
    logic                        pick_found;
    logic [ID_W-1:0]             pick_id;

    assign sel_byte = req_data[int'(grant)*8 +: 8];
    assign sel_last = req_last[grant];
    assign accept   = |(req_valid & req_ready);
    assign hash_id  = grant;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    pearson_step u_step0 (
        .tbl     (tbl),
        .h_in    (h0),
        .data_in (sel_byte),
        .h_next  (h0_next)
    );

`ifdef PEARSON_WIDE_EN
    logic [7:0] h1;
    logic [7:0] h1_next;
    logic [7:0] lane1_h_in;
    logic [7:0] lane1_data;
    logic       first_byte;

    // Lane1 seeds from T[byte0 + 1]; that is a normal step from h=0 with the byte bumped.
    assign lane1_h_in = first_byte ? 8'h00 : h1;
    assign lane1_data = first_byte ? sel_byte + 8'd1 : sel_byte;

    pearson_step u_step1 (
        .tbl     (tbl),
        .h_in    (lane1_h_in),
        .data_in (lane1_data),
        .h_next  (h1_next)
    );

    assign hash_data = {h1, h0};
`else
    assign hash_data = h0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            h0           <= 8'h00;
            req_ready    <= '0;
            tbl_wr_ready <= 1'b0;
            hash_valid   <= 1'b0;
            busy         <= 1'b0;
            tbl          <= DEFAULT_TABLE;
`ifdef PEARSON_WIDE_EN
            h1           <= 8'h00;
            first_byte   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (tbl_wr_ready && tbl_wr_en) begin
                        tbl[tbl_wr_addr] <= tbl_wr_data;
                    end else if (tbl_wr_ready && pick_found) begin
                        grant        <= pick_id;
                        h0           <= 8'h00;
                        req_ready    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
                        tbl_wr_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= STREAM;
`ifdef PEARSON_WIDE_EN
                        h1           <= 8'h00;
                        first_byte   <= 1'b1;
`endif
                    end else begin
                        tbl_wr_ready <= 1'b1;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        h0 <= h0_next;
`ifdef PEARSON_WIDE_EN
                        h1         <= h1_next;
                        first_byte <= 1'b0;
`endif
                        if (sel_last) begin
                            req_ready  <= '0;
                            hash_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (hash_ready) begin
                        hash_valid   <= 1'b0;
                        rr_ptr       <= ID_W'((int'(grant) + 1) % NUM_REQ);
                        tbl_wr_ready <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pearson_hash_scheduler.sv
// tb/tb_pearson_hash_scheduler.sv - randomized self-checking bench with a behavioural Pearson hash model
module tb_pearson_hash_scheduler;

`ifdef PEARSON_WIDE_EN
    localparam int HW = 16;
`else
    localparam int HW = 8;
`endif

    logic          clock;
    logic          reset;
    logic [3:0]    req_valid;
    logic [31:0]   req_data;
    logic [3:0]    req_last;
    logic [3:0]    req_ready;
    logic          tbl_wr_en;
    logic [7:0]    tbl_wr_addr;
    logic [7:0]    tbl_wr_data;
    logic          tbl_wr_ready;
    logic          hash_valid;
    logic [HW-1:0] hash_data;
    logic [1:0]    hash_id;
    logic          hash_ready;
    logic          busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] tbl_m [256];
    logic [7:0] msg_q [$];

    pearson_hash_scheduler #(.NUM_REQ(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_wr_addr  (tbl_wr_addr),
        .tbl_wr_data  (tbl_wr_data),
        .tbl_wr_ready (tbl_wr_ready),
        .hash_valid   (hash_valid),
        .hash_data    (hash_data),
        .hash_id      (hash_id),
        .hash_ready   (hash_ready),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset_table();
        for (int i = 0; i < 256; i++) tbl_m[i] = 8'((i * 167 + 13) & 255);
    endtask

    // Digest of msg_q under the current model table: lane0 from h=0, lane1 seeded by T[b0+1].
    function automatic logic [15:0] model_hash();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h00;
        foreach (msg_q[k]) a = tbl_m[a ^ msg_q[k]];
        b = tbl_m[8'(msg_q[0] + 8'd1)];
        for (int k = 1; k < msg_q.size(); k++) b = tbl_m[b ^ msg_q[k]];
`ifdef PEARSON_WIDE_EN
        return {b, a};
`else
        return {8'h00, a};
`endif
    endfunction

    task automatic tbl_write(input logic [7:0] a, input logic [7:0] d);
        int cyc;
        cyc = 0;
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = a;
        tbl_wr_data = d;
        while (!tbl_wr_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        if (cyc >= 50) check("wr_ready_timeout", 32'(tbl_wr_ready), 32'd1);
        tick();
        tbl_wr_en = 1'b0;
        tbl_m[a]  = d;
    endtask

    // Send msg_q on requester id; DUT must be idle and write-ready on entry.
    task automatic do_msg(input int id, input bit stall, input int hold);
        logic [15:0] exp_h;
        int          i;
        int          cyc;
        logic        acc;
        exp_h = model_hash();
        i     = 0;
        cyc   = 0;
        while (i < msg_q.size() && cyc < 400) begin
            req_valid[id]       = !(stall && $urandom_range(0, 3) == 0);
            req_data[id*8 +: 8] = msg_q[i];
            req_last[id]        = (i == msg_q.size() - 1);
            acc = req_valid[id] & req_ready[id];
            check("ready_other", 32'(req_ready & ~(4'b0001 << id)), 32'd0);
            tick();
            cyc++;
            if (acc) i++;
        end
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
        if (i < msg_q.size()) check("accept_timeout", 32'(i), 32'(msg_q.size()));
        if (!stall) check("latency", 32'(cyc), 32'(msg_q.size() + 1));
        while (!hash_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        check("hash_valid", 32'(hash_valid), 32'd1);
        check("hash_data", 32'(hash_data), 32'(exp_h[HW-1:0]));
        check("hash_id", 32'(hash_id), 32'(id));
        check("done_req_ready", 32'(req_ready), 32'd0);
        check("done_wr_ready", 32'(tbl_wr_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            tick();
            check("hold_valid", 32'(hash_valid), 32'd1);
            check("hold_data", 32'(hash_data), 32'(exp_h[HW-1:0]));
            check("hold_id", 32'(hash_id), 32'(id));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_wr_ready", 32'(tbl_wr_ready), 32'd0);
        end
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        check("post_valid", 32'(hash_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_wr_ready", 32'(tbl_wr_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_hash_valid"}, 32'(hash_valid), 32'd0);
        check({tag, "_hash_data"}, 32'(hash_data), 32'd0);
        check({tag, "_hash_id"}, 32'(hash_id), 32'd0);
        check({tag, "_wr_ready"}, 32'(tbl_wr_ready), 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();
        check("rst_wr_ready_up", 32'(tbl_wr_ready), 32'd1);
        model_reset_table();
    endtask

    initial begin
        int got;
        int cyc;
        logic [7:0] rr_bytes [4];
        logic [15:0] exp_h;

        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
        tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0; hash_ready = 1'b0;
        apply_reset();

        // Default table digest of a single byte
        msg_q = '{8'($urandom_range(0, 255))};
        do_msg(2, 1'b0, 0);

        // Identity table, req0 sends 0x5A
        for (int i = 0; i < 256; i++) tbl_write(8'(i), 8'(i));
        msg_q = '{8'h5A};
        do_msg(0, 1'b0, 0);
`ifdef PEARSON_WIDE_EN
        msg_q = '{8'h10};
        do_msg(1, 1'b0, 0);
        msg_q = '{8'h10};
        exp_h = model_hash();
        check("wide_identity_model", 32'(exp_h), 32'h1110);
`endif

        // Inverted table, req1 sends {01,02} and consumer stalls 5 cycles
        for (int i = 0; i < 256; i++) tbl_write(8'(i), ~8'(i));
        msg_q = '{8'h01, 8'h02};
        exp_h = model_hash();
        check("inv_model_lane0", 32'(exp_h[7:0]), 32'h03);
        do_msg(1, 1'b0, 5);

        // Write and request in the same idle cycle: the write lands first
        tbl_wr_en = 1'b1; tbl_wr_addr = 8'h33; tbl_wr_data = 8'hC4;
        req_valid[2] = 1'b1; req_data[23:16] = 8'h33; req_last[2] = 1'b1;
        check("coll_pre_wr_ready", 32'(tbl_wr_ready), 32'd1);
        tick();
        tbl_wr_en = 1'b0;
        tbl_m[8'h33] = 8'hC4;
        check("coll_no_grant_busy", 32'(busy), 32'd0);
        check("coll_no_grant_ready", 32'(req_ready), 32'd0);
        tick();
        check("coll_grant_ready", 32'(req_ready), 32'h4);
        check("coll_grant_busy", 32'(busy), 32'd1);
        tick();
        req_valid[2] = 1'b0; req_last[2] = 1'b0;
        msg_q = '{8'h33};
        exp_h = model_hash();
        check("coll_valid", 32'(hash_valid), 32'd1);
        check("coll_lane0", 32'(hash_data[7:0]), 32'hC4);
        check("coll_data", 32'(hash_data), 32'(exp_h[HW-1:0]));
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;

        // Randomized messages with random stalls and random table edits
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) tbl_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            msg_q.delete();
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) msg_q.push_back(8'($urandom_range(0, 255)));
            do_msg(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Round-robin order with all requesters asking continuously
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            rr_bytes[r] = 8'($urandom_range(0, 255));
            req_data[r*8 +: 8] = rr_bytes[r];
        end
        req_last = 4'hF; req_valid = 4'hF; hash_ready = 1'b1;
        got = 0; cyc = 0;
        while (got < 5 && cyc < 100) begin
            check("rr_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (hash_valid) begin
                msg_q = '{rr_bytes[got % 4]};
                exp_h = model_hash();
                check("rr_id", 32'(hash_id), 32'(got % 4));
                check("rr_data", 32'(hash_data), 32'(exp_h[HW-1:0]));
                got++;
            end
            tick();
            cyc++;
        end
        if (got < 5) check("rr_timeout", 32'(got), 32'd5);
        req_valid = '0; req_last = '0;
        while (busy && cyc < 120) begin
            tick();
            cyc++;
        end
        hash_ready = 1'b0;
        tick();

        // Reset in the middle of a message restores the default table
        for (int i = 0; i < 8; i++) tbl_write(8'(i), 8'(8'hA0 + i));
        req_valid[3] = 1'b1; req_data[31:24] = 8'h07; req_last[3] = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1; req_valid = '0;
        tick();
        check_reset_outputs("mid_rst");
        reset = 1'b0;
        tick();
        model_reset_table();
        for (int i = 0; i < 8; i++) begin
            msg_q = '{8'(i)};
            do_msg(3, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
